// File: rtl/logic_unit.sv
// Registered bitwise ALU (OR/AND/XOR/NAND) with zero flag and ones count; 1-cycle latency, in_ready = !out_valid || out_ready.
// Optional accumulator operand compiled in with LOGIC_UNIT_ACC_EN.
module logic_unit #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic [CW-1:0]    ones
);

    typedef enum logic [1:0] {
        OP_OR   = 2'b00,
        OP_AND  = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    logic             accept;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    res_ones;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef LOGIC_UNIT_ACC_EN
    logic [WIDTH-1:0] acc_q;

    // A clear coinciding with an accumulate makes the accumulator read as zero.
    assign a_eff = acc ? (acc_clr ? '0 : acc_q) : a;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (accept && acc) begin
            acc_q <= res;
        end else if (acc_clr) begin
            acc_q <= '0;
        end
    end
`else
    logic unused_acc;

    assign a_eff      = a;
    assign unused_acc = acc ^ acc_clr;
`endif

    always_comb begin
        res = '0;
        case (op_e'(op))
            OP_OR:   res = a_eff | b;
            OP_AND:  res = a_eff & b;
            OP_XOR:  res = a_eff ^ b;
            OP_NAND: res = ~(a_eff & b);
            default: res = '0;
        endcase
    end

    always_comb begin
        res_ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            res_ones = res_ones + CW'(res[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            zero      <= 1'b1;
            ones      <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            y         <= res;
            zero      <= (res == '0);
            ones      <= res_ones;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_unit.sv
// Randomised self-checking bench for logic_unit (WIDTH=8) against a queue-free behavioural model.
module tb_logic_unit;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [1:0]    op = '0;
    logic          acc = 1'b0;
    logic          acc_clr = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  y;
    logic          zero;
    logic [CW-1:0] ones;

    int checks = 0;
    int errors = 0;

    // Model state
    logic         m_vld;
    logic [W-1:0] m_y;
    logic [W-1:0] m_acc;
    logic         m_rdy;
    logic         got_rdy;

    always #5 clk = ~clk;

    logic_unit #(.WIDTH(W), .CW(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .acc(acc), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero), .ones(ones)
    );

    function automatic logic [CW-1:0] exp_ones(input logic [W-1:0] v);
        return CW'($countones(v));
    endfunction

    // Drives one cycle of inputs, records in_ready before the edge and advances the model.
    task automatic apply(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [1:0] iop, input logic iacc, input logic iclr,
                         input logic iordy);
        logic [W-1:0] aeff;
        logic [W-1:0] res;
        logic         acpt;
        in_valid = iv; a = ia; b = ib; op = iop; acc = iacc; acc_clr = iclr; out_ready = iordy;
        #1;
        got_rdy = in_ready;
        m_rdy   = !m_vld || iordy;
        acpt    = iv && m_rdy;
        aeff    = ia;
`ifdef LOGIC_UNIT_ACC_EN
        if (iacc) aeff = iclr ? '0 : m_acc;
`endif
        case (iop)
            2'd0:    res = aeff | ib;
            2'd1:    res = aeff & ib;
            2'd2:    res = aeff ^ ib;
            default: res = ~(aeff & ib);
        endcase
        if (acpt) begin
            m_vld = 1'b1;
            m_y   = res;
        end else if (iordy) begin
            m_vld = 1'b0;
        end
`ifdef LOGIC_UNIT_ACC_EN
        if (acpt && iacc) m_acc = res;
        else if (iclr)    m_acc = '0;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; acc = 1'b0; acc_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_vld = 1'b0; m_y = '0; m_acc = '0;
        #1;
        checks++;
        if ({out_valid, y, zero, ones, in_ready} !== {1'b0, 8'h00, 1'b1, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset: vld=%b y=%h zero=%b ones=%0d rdy=%b required 0 00 1 0 1",
                     out_valid, y, zero, ones, in_ready);
        end
    endtask

    task automatic test_ops;
        logic [W-1:0]  ey [4];
        logic [CW-1:0] eo [4];
        ey = '{8'hFC, 8'h30, 8'hCC, 8'hCF};
        eo = '{4'd6, 4'd2, 4'd4, 4'd6};
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 8'hF0, 8'h3C, 2'(i), 1'b0, 1'b0, 1'b1);
            checks++;
            if ({out_valid, y, zero, ones} !== {1'b1, ey[i], 1'b0, eo[i]}) begin
                errors++;
                $display("FAIL op%0d: vld=%b y=%h zero=%b ones=%0d required 1 %h 0 %0d",
                         i, out_valid, y, zero, ones, ey[i], eo[i]);
            end
        end
    endtask

    task automatic test_zero;
        apply(1'b1, 8'h0F, 8'hF0, 2'b01, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({out_valid, y, zero, ones} !== {1'b1, 8'h00, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL zero_result: vld=%b y=%h zero=%b ones=%0d required 1 00 1 0",
                     out_valid, y, zero, ones);
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] held;
        apply(1'b1, 8'h5A, 8'h0F, 2'b10, 1'b0, 1'b0, 1'b1);
        held = m_y;
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 8'hAA, 8'h55, 2'b00, 1'b0, 1'b0, 1'b0);
            checks++;
            if ({got_rdy, out_valid, y} !== {1'b0, 1'b1, held}) begin
                errors++;
                $display("FAIL hold%0d: rdy=%b vld=%b y=%h required 0 1 %h",
                         i, got_rdy, out_valid, y, held);
            end
        end
        apply(1'b1, 8'h33, 8'h0F, 2'b01, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({got_rdy, out_valid, y} !== {1'b1, 1'b1, 8'h03}) begin
            errors++;
            $display("FAIL drain_accept: rdy=%b vld=%b y=%h required 1 1 03", got_rdy, out_valid, y);
        end
    endtask

    task automatic test_random;
        logic ov;
        for (int i = 0; i < 400; i++) begin
            ov = ($urandom_range(0, 3) != 0);
            apply(logic'($urandom_range(0, 1)), W'($urandom), W'($urandom), 2'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0), ov);
            checks++;
            if (got_rdy !== m_rdy) begin
                errors++;
                $display("FAIL rand_rdy[%0d]: in_ready=%b required %b", i, got_rdy, m_rdy);
            end
            checks++;
            if (m_vld) begin
                if ({out_valid, y, zero, ones} !== {1'b1, m_y, (m_y == '0), exp_ones(m_y)}) begin
                    errors++;
                    $display("FAIL rand_out[%0d]: vld=%b y=%h zero=%b ones=%0d required 1 %h %b %0d",
                             i, out_valid, y, zero, ones, m_y, (m_y == '0), exp_ones(m_y));
                end
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rand_vld[%0d]: out_valid=%b required 0", i, out_valid);
            end
        end
    endtask

    task automatic test_acc;
        logic [W-1:0] ey [5];
`ifdef LOGIC_UNIT_ACC_EN
        ey = '{8'h01, 8'h03, 8'h07, 8'hF8, 8'h7E};
        apply(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1);
        apply(1'b1, 8'hAA, 8'h01, 2'b00, 1'b1, 1'b0, 1'b1);
        checks++;
        if (y !== ey[0]) begin errors++; $display("FAIL acc0: y=%h required %h", y, ey[0]); end
        apply(1'b1, 8'hAA, 8'h02, 2'b00, 1'b1, 1'b0, 1'b1);
        checks++;
        if (y !== ey[1]) begin errors++; $display("FAIL acc1: y=%h required %h", y, ey[1]); end
        apply(1'b1, 8'hAA, 8'h04, 2'b00, 1'b1, 1'b0, 1'b1);
        checks++;
        if (y !== ey[2]) begin errors++; $display("FAIL acc2: y=%h required %h", y, ey[2]); end
        apply(1'b1, 8'hAA, 8'hFF, 2'b10, 1'b1, 1'b0, 1'b1);
        checks++;
        if (y !== ey[3]) begin errors++; $display("FAIL acc_xor: y=%h required %h", y, ey[3]); end
        apply(1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 1'b1);
        apply(1'b1, 8'h11, 8'h7E, 2'b00, 1'b1, 1'b0, 1'b1);
        checks++;
        if (y !== ey[4]) begin errors++; $display("FAIL acc_load: y=%h required %h", y, ey[4]); end
        apply(1'b1, 8'h11, 8'h81, 2'b00, 1'b1, 1'b1, 1'b1);
        checks++;
        if (y !== 8'h81) begin errors++; $display("FAIL acc_clr_collide: y=%h required 81", y); end
        apply(1'b1, 8'h11, 8'h00, 2'b00, 1'b1, 1'b0, 1'b1);
        checks++;
        if (y !== 8'h81) begin errors++; $display("FAIL acc_after_collide: y=%h required 81", y); end
`else
        ey = '{8'h5F, 8'h0F, 8'h50, 8'h00, 8'h00};
        apply(1'b1, 8'h55, 8'h0F, 2'b00, 1'b1, 1'b1, 1'b1);
        checks++;
        if (y !== ey[0]) begin errors++; $display("FAIL acc_ignored_or: y=%h required %h", y, ey[0]); end
        apply(1'b1, 8'h5F, 8'h0F, 2'b01, 1'b1, 1'b0, 1'b1);
        checks++;
        if (y !== ey[1]) begin errors++; $display("FAIL acc_ignored_and: y=%h required %h", y, ey[1]); end
        apply(1'b1, 8'h5F, 8'h0F, 2'b10, 1'b1, 1'b0, 1'b1);
        checks++;
        if (y !== ey[2]) begin errors++; $display("FAIL acc_ignored_xor: y=%h required %h", y, ey[2]); end
`endif
    endtask

    task automatic test_reset_held;
        apply(1'b1, 8'hC3, 8'h3C, 2'b00, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 8'h12, 8'h34, 2'b10, 1'b1, 1'b0, 1'b0);
        rst = 1'b1; in_valid = 1'b1; acc_clr = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; acc_clr = 1'b0;
        m_vld = 1'b0; m_y = '0; m_acc = '0;
        #1;
        checks++;
        if ({out_valid, y, zero, ones, in_ready} !== {1'b0, 8'h00, 1'b1, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_held: vld=%b y=%h zero=%b ones=%0d rdy=%b required 0 00 1 0 1",
                     out_valid, y, zero, ones, in_ready);
        end
        @(posedge clk);
        #1;
        // Accumulator (when present) must also have been cleared by reset.
        apply(1'b1, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 1'b1);
        checks++;
        if ({out_valid, y} !== {1'b1, m_y}) begin
            errors++;
            $display("FAIL post_reset_acc: vld=%b y=%h required 1 %h", out_valid, y, m_y);
        end
    endtask

    initial begin
        m_vld = 1'b0; m_y = '0; m_acc = '0; m_rdy = 1'b1; got_rdy = 1'b0;
        test_reset;
        test_ops;
        test_zero;
        test_backpressure;
        test_acc;
        test_random;
        test_reset_held;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_unit.md
LOGIC_UNIT -- requirements
Module: logic_unit

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 2..32.
REQ-002 Parameter CW, default $clog2(WIDTH+1): width of the ones-count output.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  the operand set on a, b, op, acc is valid.
REQ-006 in_ready  output  1  the block can accept an operand set this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  2  operation select: 00 OR, 01 AND, 10 XOR, 11 NAND.
REQ-010 acc  input  1  use the accumulator in place of operand A.
REQ-011 acc_clr  input  1  clear the accumulator.
REQ-012 out_valid  output  1  y, zero and ones hold a result.
REQ-013 out_ready  input  1  the downstream consumer takes the result this cycle.
REQ-014 y  output  WIDTH  registered result.
REQ-015 zero  output  1  y is all zeros.
REQ-016 ones  output  CW  number of 1 bits in y.

Function
REQ-017 The block SHALL accept an operand set when in_valid=1 and in_ready=1 (an accept).
REQ-018 in_ready SHALL equal (!out_valid || out_ready), so a held result back-pressures the input with no combinational path from in_valid.
REQ-019 On an accept, the result SHALL be op(Aeff, b) bitwise across WIDTH bits; Aeff = a when acc=0, the accumulator value otherwise; NAND = ~(Aeff & b).
REQ-020 Latency SHALL be 1 cycle: the result computed on an accept is on y, zero and ones on the next cycle, with out_valid=1.
REQ-021 zero and ones SHALL be registered together with y and SHALL always match y.
REQ-022 While out_valid=1 and out_ready=0, y, zero, ones and out_valid SHALL hold.
REQ-023 out_valid SHALL clear after a cycle with out_valid=1 and out_ready=1 that has no accept.
REQ-024 An accept in the same cycle as a drain (out_ready=1) SHALL load the new result with no bubble, giving full throughput of one result per cycle.
REQ-025 The accumulator SHALL be a WIDTH-bit register that loads the result on every accept with acc=1; in all other cycles it holds.
REQ-026 acc_clr=1 SHALL set the accumulator to 0 on the next edge, unless an accept with acc=1 occurs in the same cycle.
REQ-027 acc_clr=1 together with an accept with acc=1 SHALL use Aeff=0, and the accumulator SHALL load the result.
REQ-028 An accept with acc=0 SHALL leave the accumulator unchanged, apart from acc_clr.
REQ-029 in_valid=1 with in_ready=0 SHALL NOT change any state; the source holds its operands until accepted.

Reset
REQ-030 With rst=1 at an edge, out_valid, y and the accumulator SHALL become 0, zero SHALL become 1, and ones SHALL become 0.
REQ-031 Reset SHALL discard any held result; in_ready SHALL read 1 in the first cycle after reset is released.
REQ-032 rst SHALL take priority over accepts and over acc_clr in the same cycle.

Configuration
REQ-033 Macro LOGIC_UNIT_ACC_EN compiles in the accumulator (REQ-025..REQ-028).
REQ-034 Without LOGIC_UNIT_ACC_EN, acc and acc_clr SHALL be ignored, Aeff SHALL always be a, and no accumulator register SHALL exist.
REQ-035 All other behaviour SHALL be identical with and without LOGIC_UNIT_ACC_EN.

Verification (WIDTH=8)
REQ-036 Each op applied to a=0xF0, b=0x3C, acc=0, out_ready=1 -> next cycle y=0xFC/0x30/0xCC/0xCF, ones=6/2/4/6, zero=0.
REQ-037 Accept a=0x0F, b=0xF0, op=01 -> y=0x00, zero=1, ones=0.
REQ-038 out_ready=0 for 3 cycles after a result -> in_ready=0 and y held for those 3 cycles; then out_ready=1 with in_valid=1 -> new result on the next cycle with no bubble.
REQ-039 With LOGIC_UNIT_ACC_EN: acc_clr, then accepts with acc=1, op=00 and b=0x01, 0x02, 0x04 -> y=0x01, 0x03, 0x07; then acc=1, op=10, b=0xFF -> y=0xF8.
REQ-040 acc_clr together with an accept acc=1, op=00, b=0x81 while the accumulator is 0x7E -> y=0x81.
REQ-041 rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, y=0x00, zero=1, in_ready=1.
